// File: rtl/key_debouncer.sv
// Push-button conditioner: 2-flop synchroniser plus a per-button debounce FSM
// producing a clean level, press/release strobes and a long-press flag.

module key_debouncer_lane #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int LONG_CYCLES     = 50_000_000
) (
   input  logic clk_clk,
   input  logic reset_reset_n,
   input  logic i_s,
   output logic o_level,
   output logic o_press,
   output logic o_release,
   output logic o_long,
   output logic o_long_pulse
);
   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   localparam int LW = $clog2(LONG_CYCLES);
   localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [LW-1:0] LG_MAX = LW'(LONG_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

   state_t          r_state;
   logic [DW-1:0]   r_db_cnt;
   logic [LW-1:0]   r_long_cnt;
   logic            r_level, r_press, r_release, r_long, r_long_pulse;

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_state      <= IDLE;
         r_db_cnt     <= '0;
         r_long_cnt   <= '0;
         r_level      <= 1'b0;
         r_press      <= 1'b0;
         r_release    <= 1'b0;
         r_long       <= 1'b0;
         r_long_pulse <= 1'b0;
      end else begin
         r_press      <= 1'b0;
         r_release    <= 1'b0;
         r_long_pulse <= 1'b0;
         case (r_state)
            IDLE: begin
               if (i_s) begin
                  r_state  <= PRESS_WAIT;
                  r_db_cnt <= '0;
               end
            end
            PRESS_WAIT: begin
               if (!i_s) begin
                  r_state <= IDLE;
               end else if (r_db_cnt == DB_MAX) begin
                  r_state    <= HELD;
                  r_level    <= 1'b1;
                  r_press    <= 1'b1;
                  r_long_cnt <= '0;
               end else begin
                  r_db_cnt <= r_db_cnt + 1'b1;
               end
            end
            HELD: begin
               // Long count keeps running on the cycle that leaves for RELEASE_WAIT.
               if (r_long_cnt != LG_MAX) begin
                  r_long_cnt <= r_long_cnt + 1'b1;
               end else if (!r_long) begin
                  r_long       <= 1'b1;
                  r_long_pulse <= 1'b1;
               end
               if (!i_s) begin
                  r_state  <= RELEASE_WAIT;
                  r_db_cnt <= '0;
               end
            end
            RELEASE_WAIT: begin
               if (i_s) begin
                  r_state <= HELD;
               end else if (r_db_cnt == DB_MAX) begin
                  r_state   <= IDLE;
                  r_level   <= 1'b0;
                  r_release <= 1'b1;
                  r_long    <= 1'b0;
               end else begin
                  r_db_cnt <= r_db_cnt + 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_level      = r_level;
   assign o_press      = r_press;
   assign o_release    = r_release;
   assign o_long       = r_long;
   assign o_long_pulse = r_long_pulse;
endmodule

module key_debouncer #(
   parameter int N_BTN           = 4,
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int LONG_CYCLES     = 50_000_000
) (
   input  logic             clk_clk,
   input  logic             reset_reset_n,
   input  logic [N_BTN-1:0] key_n_i,
   output logic [N_BTN-1:0] btn_level_o,
   output logic [N_BTN-1:0] btn_press_o,
   output logic [N_BTN-1:0] btn_release_o,
   output logic [N_BTN-1:0] btn_long_o,
   output logic [N_BTN-1:0] btn_long_pulse_o
);
   logic [N_BTN-1:0] r_sync1, r_sync2;
   logic [N_BTN-1:0] w_s;

   // Synchroniser resets to "released" so a pin held low at reset is seen as a new press.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_sync1 <= '1;
         r_sync2 <= '1;
      end else begin
         r_sync1 <= key_n_i;
         r_sync2 <= r_sync1;
      end
   end

   assign w_s = ~r_sync2;

   for (genvar g = 0; g < N_BTN; g++) begin : g_lane
      key_debouncer_lane #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .LONG_CYCLES     (LONG_CYCLES)
      ) u_lane (
         .clk_clk      (clk_clk),
         .reset_reset_n(reset_reset_n),
         .i_s          (w_s[g]),
         .o_level      (btn_level_o[g]),
         .o_press      (btn_press_o[g]),
         .o_release    (btn_release_o[g]),
         .o_long       (btn_long_o[g]),
         .o_long_pulse (btn_long_pulse_o[g])
      );
   end
endmodule

// File: tb/tb_key_debouncer.sv
// Bench for key_debouncer: scenario tasks push expected strobes with their edge
// numbers; a per-edge monitor pops them and compares every output vector.

module tb_key_debouncer;
   localparam int N  = 4;
   localparam int DB = 4;
   localparam int LG = 16;

   logic         clk_clk = 1'b0;
   logic         reset_reset_n = 1'b0;
   logic [N-1:0] key_n_i = '1;
   logic [N-1:0] btn_level_o, btn_press_o, btn_release_o, btn_long_o, btn_long_pulse_o;

   key_debouncer #(.N_BTN(N), .DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LG)) dut (
      .clk_clk         (clk_clk),
      .reset_reset_n   (reset_reset_n),
      .key_n_i         (key_n_i),
      .btn_level_o     (btn_level_o),
      .btn_press_o     (btn_press_o),
      .btn_release_o   (btn_release_o),
      .btn_long_o      (btn_long_o),
      .btn_long_pulse_o(btn_long_pulse_o)
   );

   initial forever #5 clk_clk = ~clk_clk;

   typedef struct {int cyc; int kind; int btn;} ev_t;  // kind: 0 press, 1 release, 2 long
   ev_t sb[$];
   int  cyc = 0;
   int  errors = 0;
   int  checks = 0;
   logic [N-1:0] exp_lvl = '0, exp_long = '0;

   task automatic push(input int c, input int kind, input logic [N-1:0] mask);
      for (int b = 0; b < N; b++)
         if (mask[b]) sb.push_back('{cyc: c, kind: kind, btn: b});
   endtask

   // Monitor: sample 1 time unit after each rising edge.
   initial begin
      logic [N-1:0] e_press, e_rel, e_lp;
      forever begin
         @(posedge clk_clk);
         cyc++;
         #1;
         e_press = '0; e_rel = '0; e_lp = '0;
         if (!reset_reset_n) begin
            sb.delete();
            exp_lvl = '0;
            exp_long = '0;
         end
         for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
               case (sb[i].kind)
                  0: begin e_press[sb[i].btn] = 1'b1; exp_lvl[sb[i].btn] = 1'b1; end
                  1: begin e_rel[sb[i].btn] = 1'b1; exp_lvl[sb[i].btn] = 1'b0; exp_long[sb[i].btn] = 1'b0; end
                  default: begin e_lp[sb[i].btn] = 1'b1; exp_long[sb[i].btn] = 1'b1; end
               endcase
               sb.delete(i);
            end
         end
         checks += 5;
         if (btn_press_o !== e_press) begin
            errors++; $display("FAIL press edge=%0d got=%b want=%b", cyc, btn_press_o, e_press);
         end
         if (btn_release_o !== e_rel) begin
            errors++; $display("FAIL release edge=%0d got=%b want=%b", cyc, btn_release_o, e_rel);
         end
         if (btn_long_pulse_o !== e_lp) begin
            errors++; $display("FAIL long_pulse edge=%0d got=%b want=%b", cyc, btn_long_pulse_o, e_lp);
         end
         if (btn_level_o !== exp_lvl) begin
            errors++; $display("FAIL level edge=%0d got=%b want=%b", cyc, btn_level_o, exp_lvl);
         end
         if (btn_long_o !== exp_long) begin
            errors++; $display("FAIL long edge=%0d got=%b want=%b", cyc, btn_long_o, exp_long);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired at edge %0d", cyc);
      $fatal(1);
   end

   task automatic test_reset();
      int k, j;
      reset_reset_n = 1'b0;
      key_n_i = 4'b0000;
      repeat (3) @(negedge clk_clk);
      checks++;
      if ({btn_level_o, btn_press_o, btn_release_o, btn_long_o, btn_long_pulse_o} !== '0) begin
         errors++; $display("FAIL reset_outputs got=%b%b%b%b%b want=0", btn_level_o, btn_press_o,
                            btn_release_o, btn_long_o, btn_long_pulse_o);
      end
      reset_reset_n = 1'b1;
      k = cyc + 1;
      push(k + 6, 0, 4'b1111);
      repeat (8) @(negedge clk_clk);
      checks++;
      if (btn_level_o !== 4'b1111) begin
         errors++; $display("FAIL reset_press_level got=%b want=1111", btn_level_o);
      end
      repeat (3) @(negedge clk_clk);
      key_n_i = 4'b1111;
      j = cyc + 1;
      push(j + 6, 1, 4'b1111);
      repeat (10) @(negedge clk_clk);
      checks++;
      if (btn_level_o !== 4'b0000) begin
         errors++; $display("FAIL reset_release_level got=%b want=0000", btn_level_o);
      end
   endtask

   task automatic test_clean_press();
      int k, j;
      @(negedge clk_clk);
      key_n_i[0] = 1'b0;
      k = cyc + 1;
      push(k + 6, 0, 4'b0001);
      push(k + 6 + LG, 2, 4'b0001);
      repeat (30) @(negedge clk_clk);
      checks++;
      if (btn_long_o[0] !== 1'b1) begin
         errors++; $display("FAIL clean_long_held got=%b want=1", btn_long_o[0]);
      end
      key_n_i[0] = 1'b1;
      j = cyc + 1;
      push(j + 6, 1, 4'b0001);
      repeat (5) @(negedge clk_clk);
      checks++;
      if (btn_long_o[0] !== 1'b1) begin
         errors++; $display("FAIL clean_long_before_release got=%b want=1", btn_long_o[0]);
      end
      repeat (3) @(negedge clk_clk);
      checks++;
      if (btn_long_o[0] !== 1'b0) begin
         errors++; $display("FAIL clean_long_after_release got=%b want=0", btn_long_o[0]);
      end
   endtask

   task automatic test_bounce();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_clk);
         key_n_i[1] = 1'b0;
         @(negedge clk_clk);
         @(negedge clk_clk);
         key_n_i[1] = 1'b1;
         @(negedge clk_clk);
      end
      repeat (10) @(negedge clk_clk);
      checks++;
      if (btn_level_o[1] !== 1'b0) begin
         errors++; $display("FAIL bounce_level got=%b want=0", btn_level_o[1]);
      end
   endtask

   task automatic test_hold_bounce();
      int k, j;
      @(negedge clk_clk);
      key_n_i[2] = 1'b0;
      k = cyc + 1;
      push(k + 6, 0, 4'b0100);
      // three frozen long-count cycles while in RELEASE_WAIT
      push(k + 6 + LG + 3, 2, 4'b0100);
      repeat (10) @(negedge clk_clk);
      key_n_i[2] = 1'b1;
      repeat (3) @(negedge clk_clk);
      key_n_i[2] = 1'b0;
      repeat (17) @(negedge clk_clk);
      key_n_i[2] = 1'b1;
      j = cyc + 1;
      push(j + 6, 1, 4'b0100);
      repeat (10) @(negedge clk_clk);
      checks++;
      if (btn_long_o[2] !== 1'b0) begin
         errors++; $display("FAIL hold_bounce_long_clear got=%b want=0", btn_long_o[2]);
      end
   endtask

   task automatic test_simultaneous();
      int k, j;
      @(negedge clk_clk);
      key_n_i = 4'b0110;
      k = cyc + 1;
      push(k + 6, 0, 4'b1001);
      push(k + 6 + LG, 2, 4'b1001);
      repeat (7) @(negedge clk_clk);
      checks++;
      if (btn_press_o !== 4'b1001) begin
         errors++; $display("FAIL simul_press got=%b want=1001", btn_press_o);
      end
      repeat (23) @(negedge clk_clk);
      key_n_i = 4'b1111;
      j = cyc + 1;
      push(j + 6, 1, 4'b1001);
      repeat (10) @(negedge clk_clk);
   endtask

   task automatic test_reset_mid_hold();
      int k, j;
      @(negedge clk_clk);
      key_n_i[1] = 1'b0;
      k = cyc + 1;
      push(k + 6, 0, 4'b0010);
      push(k + 6 + LG, 2, 4'b0010);
      repeat (25) @(negedge clk_clk);
      checks++;
      if (btn_long_o[1] !== 1'b1) begin
         errors++; $display("FAIL midhold_long got=%b want=1", btn_long_o[1]);
      end
      reset_reset_n = 1'b0;
      #1;
      checks++;
      if ({btn_level_o, btn_long_o} !== '0) begin
         errors++; $display("FAIL midhold_async_clear level=%b long=%b want=0", btn_level_o, btn_long_o);
      end
      repeat (3) @(negedge clk_clk);
      reset_reset_n = 1'b1;
      k = cyc + 1;
      push(k + 6, 0, 4'b0010);
      push(k + 6 + LG, 2, 4'b0010);
      repeat (30) @(negedge clk_clk);
      key_n_i[1] = 1'b1;
      j = cyc + 1;
      push(j + 6, 1, 4'b0010);
      repeat (10) @(negedge clk_clk);
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_hold_bounce();
      test_simultaneous();
      test_reset_mid_hold();
      repeat (3) @(negedge clk_clk);
      checks++;
      if (sb.size() != 0) begin
         errors++; $display("FAIL scoreboard_drain got=%0d pending want=0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
